// File: rtl/gas_level_pulse_encoder_pkg.sv
// rtl/gas_level_pulse_encoder_pkg.sv - shared frame timing constants and FSM encoding
package gas_level_pulse_encoder_pkg;

  // Defaults shared with the detector so both ends agree on frame timing.
  localparam int GAS_LEVEL_W     = 3;
  localparam int GAS_GAP_CYCLES  = 4;
  localparam int GAS_IDLE_CYCLES = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_TAIL  = 2'd3
  } gas_state_t;

  function automatic int cnt_width(input int gap_cycles, input int idle_cycles);
    int longest;
    longest = (gap_cycles > idle_cycles) ? gap_cycles : idle_cycles;
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/gas_level_pulse_encoder_if.sv
// rtl/gas_level_pulse_encoder_if.sv - level handshake and serial line bundle
interface gas_level_pulse_encoder_if #(
  parameter int LEVEL_W = 3
);
  logic [LEVEL_W-1:0] level_in;
  logic               level_valid;
  logic               level_ready;
  logic               dout;
  logic               busy;
  logic               frame_done;

  modport master (
    output level_in, level_valid,
    input  level_ready, dout, busy, frame_done
  );

  modport slave (
    input  level_in, level_valid,
    output level_ready, dout, busy, frame_done
  );
endinterface

// File: rtl/gas_level_pulse_encoder_cycle_down_counter.sv
// rtl/gas_level_pulse_encoder_cycle_down_counter.sv - loadable down-counter with zero flag
module cycle_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (arst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/gas_level_pulse_encoder.sv
// rtl/gas_level_pulse_encoder.sv - serialises a gas level as a pulse-count frame
module gas_level_pulse_encoder
  import gas_level_pulse_encoder_pkg::*;
#(
  parameter int LEVEL_W     = GAS_LEVEL_W,
  parameter int GAP_CYCLES  = GAS_GAP_CYCLES,
  parameter int IDLE_CYCLES = GAS_IDLE_CYCLES
) (
  input  logic                      clk,
  input  logic                      arst,
  gas_level_pulse_encoder_if.slave  bus
);
  localparam int CNT_W = cnt_width(GAP_CYCLES, IDLE_CYCLES);

  gas_state_t         state;
  logic [LEVEL_W-1:0] level;
  logic [LEVEL_W:0]   pulses_sent;
  logic               dout_q;
  logic               busy_q;
  logic               ready_q;
  logic               done_q;

  logic               last_pulse;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_value;
  logic               cnt_en;
  logic               cnt_zero;

  // One extra counter bit lets the maximum level send 2^LEVEL_W pulses without wrapping.
  assign last_pulse = (pulses_sent == {1'b0, level});

  always_comb begin
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_en         = 1'b0;
    if (state == ST_PULSE) begin
      cnt_load       = 1'b1;
      cnt_load_value = last_pulse ? CNT_W'(IDLE_CYCLES - 1) : CNT_W'(GAP_CYCLES - 1);
    end
    if ((state == ST_GAP) || (state == ST_TAIL)) begin
      cnt_en = 1'b1;
    end
  end

  cycle_down_counter #(
    .W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .arst       (arst),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .en         (cnt_en),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (arst) begin
      state       <= ST_IDLE;
      level       <= '0;
      pulses_sent <= '0;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ready_q && bus.level_valid) begin
            state       <= ST_PULSE;
            level       <= bus.level_in;
            pulses_sent <= '0;
            dout_q      <= 1'b1;
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_PULSE: begin
          dout_q <= 1'b0;
          if (last_pulse) begin
            state <= ST_TAIL;
          end else begin
            state       <= ST_GAP;
            pulses_sent <= pulses_sent + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_zero) begin
            state  <= ST_PULSE;
            dout_q <= 1'b1;
          end
        end
        ST_TAIL: begin
          if (cnt_zero) begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dout        = dout_q;
  assign bus.busy        = busy_q;
  assign bus.level_ready = ready_q;
  assign bus.frame_done  = done_q;
endmodule
